// File: rtl/shared_event_fifo.sv
// Shared event FIFO between the event builder/comms controller and the UART transmit path.
// Stores WIDTH-1 bit packets and provides registered occupancy/status and the last popped word.
module shared_event_fifo #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned FIFO_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset_n_clk,
    input  logic                 write_fifo_n,
    input  logic                 read_fifo_n,
    input  logic [WIDTH-2:0]     output_event,
    input  logic                 soft_clear,
    output logic [WIDTH-2:0]     tx_data,
    output logic                 fifo_full,
    output logic                 fifo_half,
    output logic                 fifo_empty,
    output logic [FIFO_BITS:0]   fifo_counter,
    output logic                 fifo_overflow
);

    localparam int unsigned DW    = WIDTH - 1;
    localparam int unsigned AW    = FIFO_BITS;
    localparam int unsigned CW    = FIFO_BITS + 1;
    localparam int unsigned DEPTH = 1 << FIFO_BITS;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          full_q, full_d;
    logic          half_q, half_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          push, pop, push_ok, pop_ok, wr_en;

    // Next-state: soft_clear wins over any push/pop; a full FIFO still accepts a push paired with a pop.
    always_comb begin
        push       = !write_fifo_n;
        pop        = !read_fifo_n;
        pop_ok     = pop && (count_q != '0);
        push_ok    = push && ((count_q != DEPTH_C) || pop_ok);
        wr_en      = push_ok && !soft_clear;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q;
        if (soft_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            tx_data_d  = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                tx_data_d = mem[rd_ptr_q];
            end
            if (push_ok && !pop_ok) count_d = count_q + CW'(1);
            if (pop_ok && !push_ok) count_d = count_q - CW'(1);
            if (push && !push_ok)   overflow_d = 1'b1;
        end
        full_d  = (count_d == DEPTH_C);
        half_d  = (count_d >= HALF_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            full_q     <= 1'b0;
            half_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            full_q     <= full_d;
            half_q     <= half_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array is deliberately not reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= output_event;
    end

    assign tx_data       = tx_data_q;
    assign fifo_full     = full_q;
    assign fifo_half     = half_q;
    assign fifo_empty    = empty_q;
    assign fifo_counter  = count_q;
    assign fifo_overflow = overflow_q;

endmodule
